// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a small input FIFO behind a valid/ready handshake.
// Frames run back-to-back whenever the FIFO still holds data at the end of a stop bit.
module uart_transmitter #(
    parameter int BAUD_RATE  = 9600,
    parameter int CLOCK_FREQ = 12000000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx,
    output logic       busy,
    output logic       fifo_empty
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q;
    logic [BW-1:0] baudCnt_q;
    logic [2:0]    bitIdx_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          busy_q;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wrPtr_q;
    logic [PW-1:0] rdPtr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    logic pushEn;
    logic popEn;
    logic baudLast;

    assign data_ready = (count_q != COUNT_FULL);
    assign fifo_empty = (count_q == '0);
    assign tx         = tx_q;
    assign busy       = busy_q;

    assign baudLast = (baudCnt_q == BAUD_LAST);
    assign pushEn   = data_valid && data_ready;
    // A pop only ever sees bytes pushed on earlier edges, since it looks at the registered count.
    assign popEn    = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && baudLast));

    always_comb begin
        count_d = count_q;
        case ({pushEn, popEn})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (pushEn) begin
            mem_q[wrPtr_q] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_d;
            if (pushEn) wrPtr_q <= wrPtr_q + 1'b1;
            if (popEn)  rdPtr_q <= rdPtr_q + 1'b1;
        end
    end

    // tx is set one state ahead so the line is always driven straight from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            baudCnt_q <= '0;
            bitIdx_q  <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (popEn) begin
                        shift_q   <= mem_q[rdPtr_q];
                        baudCnt_q <= '0;
                        state_q   <= START;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                START: begin
                    if (baudLast) begin
                        baudCnt_q <= '0;
                        bitIdx_q  <= '0;
                        state_q   <= DATA;
                        tx_q      <= shift_q[0];
                    end else begin
                        baudCnt_q <= baudCnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (baudLast) begin
                        baudCnt_q <= '0;
                        if (bitIdx_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            shift_q  <= shift_q >> 1;
                            bitIdx_q <= bitIdx_q + 1'b1;
                            tx_q     <= shift_q[1];
                        end
                    end else begin
                        baudCnt_q <= baudCnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (baudLast) begin
                        baudCnt_q <= '0;
                        if (popEn) begin
                            shift_q <= mem_q[rdPtr_q];
                            state_q <= START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        baudCnt_q <= baudCnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: random and directed pushes compared cycle by cycle
// against a frame-schedule model (each byte gets a start edge and a 10-bit waveform).
module tb_uart_transmitter;

    localparam int BAUD_RATE  = 1;
    localparam int CLOCK_FREQ = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int CPB        = CLOCK_FREQ / BAUD_RATE;
    localparam int FRAME      = 10 * CPB;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       tx;
    logic       busy;
    logic       fifo_empty;

    int vectorCount;
    int missCount;
    int edgeNum;
    int lineFree;

    int         accQ[$];
    int         startQ[$];
    logic [7:0] byteQ[$];

    uart_transmitter #(
        .BAUD_RATE (BAUD_RATE),
        .CLOCK_FREQ(CLOCK_FREQ),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .tx        (tx),
        .busy      (busy),
        .fifo_empty(fifo_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", tag, edgeNum, observed, expected);
        end
    endtask

    // Bytes accepted on or before edge e that have not yet been popped.
    function automatic int modelCount(input int e);
        int n = 0;
        foreach (accQ[i]) if (accQ[i] <= e && startQ[i] > e) n++;
        return n;
    endfunction

    function automatic logic modelBusy(input int e);
        foreach (startQ[i]) if (e >= startQ[i] && e < startQ[i] + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic modelTx(input int e);
        int k;
        logic [7:0] b;
        foreach (startQ[i]) begin
            if (e >= startQ[i] && e < startQ[i] + FRAME) begin
                k = (e - startQ[i]) / CPB;
                b = byteQ[i];
                if (k == 0) return 1'b0;
                if (k == 9) return 1'b1;
                return b[k-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic void clearModel();
        accQ.delete();
        startQ.delete();
        byteQ.delete();
        edgeNum  = 0;
        lineFree = 0;
    endfunction

    // Called just after a clock edge; drives inputs, advances one edge, then checks outputs.
    task automatic applyStimulus(input logic v, input logic [7:0] d, output logic accepted);
        int s;
        data_valid = v;
        data_in    = d;
        accepted   = v && (modelCount(edgeNum) != FIFO_DEPTH);
        @(posedge clk);
        edgeNum++;
        if (accepted) begin
            s = (edgeNum + 1 > lineFree) ? edgeNum + 1 : lineFree;
            accQ.push_back(edgeNum);
            startQ.push_back(s);
            byteQ.push_back(d);
            lineFree = s + FRAME;
        end
        #1;
        checkOutput("tx", 32'(tx), 32'(modelTx(edgeNum)));
        checkOutput("busy", 32'(busy), 32'(modelBusy(edgeNum)));
        checkOutput("data_ready", 32'(data_ready), 32'(modelCount(edgeNum) != FIFO_DEPTH));
        checkOutput("fifo_empty", 32'(fifo_empty), 32'(modelCount(edgeNum) == 0));
    endtask

    task automatic idleCycles(input int n);
        logic acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, acc);
    endtask

    initial begin
        logic       acc;
        logic [7:0] pending;
        int         nextByte;
        int         density;

        vectorCount = 0;
        missCount   = 0;
        data_valid  = 1'b0;
        data_in     = 8'h00;
        reset       = 1'b1;
        clearModel();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_tx", 32'(tx), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_data_ready", 32'(data_ready), 32'd1);
        checkOutput("reset_fifo_empty", 32'(fifo_empty), 32'd1);
        reset = 1'b0;

        idleCycles(3);

        // Single 0xAA frame.
        applyStimulus(1'b1, 8'hAA, acc);
        idleCycles(FRAME + 5);

        // Hold valid high with 1..6 so the FIFO fills and byte 6 is held off.
        nextByte = 1;
        for (int i = 0; i < 250; i++) begin
            if (nextByte <= 6) begin
                applyStimulus(1'b1, 8'(nextByte), acc);
                if (acc) nextByte++;
            end else begin
                applyStimulus(1'b0, 8'h00, acc);
            end
        end
        idleCycles(FRAME + 5);

        // Push on the last stop cycle of a frame while one byte is queued.
        clearModel();
        applyStimulus(1'b1, 8'h3C, acc);
        applyStimulus(1'b1, 8'hC3, acc);
        while (edgeNum < 2 + FRAME - 1) applyStimulus(1'b0, 8'h00, acc);
        applyStimulus(1'b1, 8'h96, acc);
        idleCycles(3 * FRAME + 5);

        // Random traffic with varying offer density; an unaccepted byte is held.
        pending = 8'($urandom);
        for (int blk = 0; blk < 20; blk++) begin
            density = $urandom_range(0, 100);
            for (int i = 0; i < 100; i++) begin
                if ($urandom_range(1, 100) <= density) begin
                    applyStimulus(1'b1, pending, acc);
                    if (acc) pending = 8'($urandom);
                end else begin
                    applyStimulus(1'b0, 8'($urandom), acc);
                end
            end
        end
        idleCycles(FIFO_DEPTH * FRAME + FRAME);

        // Reset during data bit 3 with two bytes still queued.
        clearModel();
        applyStimulus(1'b1, 8'h0F, acc);
        applyStimulus(1'b1, 8'h55, acc);
        applyStimulus(1'b1, 8'hE7, acc);
        while (edgeNum < 2 + 4 * CPB + 1) applyStimulus(1'b0, 8'h00, acc);
        #1 reset = 1'b1;
        #1;
        checkOutput("midreset_tx", 32'(tx), 32'd1);
        checkOutput("midreset_fifo_empty", 32'(fifo_empty), 32'd1);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_data_ready", 32'(data_ready), 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        clearModel();
        idleCycles(2 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
